mem_access: RTL
===============

# mem_access

Memory-access (MEM) stage of the five-stage RISC-V pipeline, sitting between the EX/MEM register and the `mem_wb` register. Turns EX results into data-memory transactions over a req/ack handshake. Performs byte/half/word lane steering and load sign/zero extension, and stalls the pipeline while an access is outstanding. Delivers rd, write-enable, load flag, ALU result and load data to MEM/WB.

## Interface
- `TIMEOUT`, default 16: WAIT cycles without `dmem_ack` before the access is aborted; range 1..255.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `valid_from_ex` in 1: EX/MEM holds a live instruction.
- `rd_from_ex` in 5: destination register.
- `write_reg_from_ex` in 1: instruction writes rd.
- `read_mem_from_ex` in 1: load.
- `write_mem_from_ex` in 1: store.
- `funct3_from_ex` in 3: size/sign; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `result_from_ex` in 32: ALU result, which is the address for memory ops.
- `store_data_from_ex` in 32: rs2 value.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write.
- `dmem_addr` out 32: word-aligned address, bits [1:0] = 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-steered store data.
- `dmem_ack` in 1: one-cycle completion pulse.
- `dmem_rdata` in 32: read word, valid with `dmem_ack`.
- `stall_to_pipe` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `bus_err` out 1: one-cycle pulse on timeout.
- `misalign_trap` out 1: one-cycle pulse; present only with `MISALIGN_TRAP_EN`.
- `rd_to_wb` out 5: feeds MEM/WB.
- `write_reg_to_wb` out 1: feeds MEM/WB.
- `read_mem_to_wb` out 1: feeds MEM/WB.
- `result_to_wb` out 32: feeds MEM/WB.
- `data_from_mem_to_wb` out 32: feeds MEM/WB.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE, non-memory op or `valid_from_ex`=0:**
  - `*_to_wb` outputs combinationally equal the EX inputs.
  - `write_reg_to_wb` = `write_reg_from_ex & valid_from_ex`.
  - `data_from_mem_to_wb` = 0, `stall_to_pipe` = 0.
- **IDLE, valid load/store:**
  - Drive `dmem_req`=1 combinationally from the inputs.
  - Capture rd, flags, funct3, address and steered store data into hold registers.
  - `stall_to_pipe`=1; go to WAIT.
- **WAIT:**
  - `dmem_req`=1, with all dmem outputs taken from the hold registers.
  - `stall_to_pipe`=1.
  - `*_to_wb` show a bubble: all zero.
  - A cycle counter increments each cycle.
  - On `dmem_ack`: register the extracted load data and go to DONE.
  - If the counter reaches `TIMEOUT` without an ack: drop `dmem_req`, pulse `bus_err`, go to DONE with write suppressed.
- **DONE, one cycle:**
  - `*_to_wb` come from the hold registers plus the registered load data.
  - `stall_to_pipe`=0; MEM/WB captures at the end of this cycle.
  - Next state is IDLE.
- **Byte enables:**
  - B: `be` = 1 << addr[1:0].
  - H: `be` = 0011 if addr[1]=0, else 1100.
  - W: `be` = 1111.
- **Store data:** replicated across lanes (byte ×4, half ×2).
- **Load data:**
  - Selected lane, sign-extended for B/H, zero-extended for BU/HU.
  - W loads pass through unchanged.
- **Stores:** `read_mem_to_wb`=0; the write flag passes as captured (normally 0).
- **`dmem_ack` outside WAIT** is ignored.
- **Reset:** state returns to IDLE, counter and hold registers clear, and any in-flight ack is ignored. While `rst`=1, all outputs read 0.

## Timing
- Non-memory op: 0 added cycles.
- Memory op:
  - Request issued in cycle T; ack arrives in T+k (k≥1).
  - DONE occurs in T+k+1.
  - `stall_to_pipe` is high for T..T+k inclusive.
- Timeout: `bus_err` is high in cycle T+`TIMEOUT`, and DONE follows in the next cycle.
- Ack in the same cycle the counter reaches `TIMEOUT`: the ack wins and `bus_err` stays 0.
- Reset values: `dmem_req`, `dmem_we`, `stall_to_pipe`, `bus_err`, `misalign_trap` are 0; every `*_to_wb` and `dmem_*` output is 0.

## Configuration
- Macro: `MEM_ACCESS_MISALIGN_TRAP_EN`.
- **Defined:** an H access with addr[0]=1, or a W access with addr[1:0]≠0:
  - issues no request and does not stall;
  - pulses `misalign_trap` for that cycle;
  - forces `write_reg_to_wb`=0.
- **Undefined:**
  - address low bits are ignored: H uses addr[1], W uses lanes 1111;
  - the access proceeds normally;
  - the `misalign_trap` port is absent.

## Test plan
- **ADD pass-through:** rd=5, result=0x1234, write_reg=1 → same-cycle `*_to_wb` match, `stall_to_pipe`=0, `dmem_req`=0.
- **LB:** addr 0x103, ack after 3 cycles with rdata 0x80FF_FF00 → `dmem_addr`=0x100, `be`=1000; stall for 4 cycles; DONE data=0xFFFF_FF80, `read_mem_to_wb`=1.
- **SH / LHU:**
  - SH addr 0x202, data 0x0000_ABCD → `be`=1100, `wdata`=0xABCD_ABCD, `we`=1.
  - LHU at same address with rdata 0xABCD_0000 → data 0x0000_ABCD.
- **No ack, TIMEOUT=4:** `bus_err` pulses at T+4; DONE has `write_reg_to_wb`=0; `dmem_req` is low afterwards.
- **Reset in WAIT:** `rst` asserted, then ack arrives → IDLE, `stall_to_pipe`=0, ack ignored, outputs 0.
- **LW addr 0x101:**
  - with the macro: `misalign_trap`=1, no request;
  - without it: `dmem_addr`=0x100, `be`=1111.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: steers EX results onto a req/ack data-memory port; optional misalign trap via MEM_ACCESS_MISALIGN_TRAP_EN.
// Latency: non-memory ops pass through in 0 cycles; memory ops add ack delay k plus one DONE cycle.
// Backpressure: stall_to_pipe holds the front of the pipe from request until ack or TIMEOUT abort.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_from_ex,
    input  logic [4:0]  rd_from_ex,
    input  logic        write_reg_from_ex,
    input  logic        read_mem_from_ex,
    input  logic        write_mem_from_ex,
    input  logic [2:0]  funct3_from_ex,
    input  logic [31:0] result_from_ex,
    input  logic [31:0] store_data_from_ex,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_to_pipe,
    output logic        bus_err,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic        misalign_trap,
`endif
    output logic [4:0]  rd_to_wb,
    output logic        write_reg_to_wb,
    output logic        read_mem_to_wb,
    output logic [31:0] result_to_wb,
    output logic [31:0] data_from_mem_to_wb
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        write_reg;
        logic        read_mem;
        logic        write_mem;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } hold_t;

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   calc_be = 4'b0001 << a;
            2'b01:   calc_be = a[1] ? 4'b1100 : 4'b0011;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   calc_wdata = {4{d[7:0]}};
            2'b01:   calc_wdata = {2{d[15:0]}};
            default: calc_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'b0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'b0, h};
            default: extract = w;
        endcase
    endfunction

    state_t      state, state_nxt;
    hold_t       hold, capture;
    logic [7:0]  cnt;
    logic [31:0] ld_data;
    logic        err;
    logic        is_mem, misalign, start, timeout;

    assign is_mem = valid_from_ex & (read_mem_from_ex | write_mem_from_ex);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign = is_mem &
                      (((funct3_from_ex[1:0] == 2'b01) & result_from_ex[0]) |
                       ((funct3_from_ex[1:0] == 2'b10) & (result_from_ex[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign start   = is_mem & ~misalign;
    // cnt is 1 in the first WAIT cycle, so equality marks cycle T+TIMEOUT
    assign timeout = (cnt == TO);

    always_comb begin
        capture.rd        = rd_from_ex;
        capture.write_reg = write_reg_from_ex;
        capture.read_mem  = read_mem_from_ex;
        capture.write_mem = write_mem_from_ex;
        capture.funct3    = funct3_from_ex;
        capture.addr      = result_from_ex;
        capture.be        = calc_be(funct3_from_ex, result_from_ex[1:0]);
        capture.wdata     = calc_wdata(funct3_from_ex, store_data_from_ex);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            cnt     <= '0;
            ld_data <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        hold    <= capture;
                        cnt     <= 8'd1;
                        ld_data <= '0;
                        err     <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (dmem_ack) begin
                        ld_data <= (hold.read_mem & ~hold.write_mem) ?
                                   extract(hold.funct3, hold.addr[1:0], dmem_rdata) : '0;
                    end else if (timeout) begin
                        err <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt           = state;
        dmem_req            = 1'b0;
        dmem_we             = 1'b0;
        dmem_addr           = '0;
        dmem_be             = '0;
        dmem_wdata          = '0;
        stall_to_pipe       = 1'b0;
        bus_err             = 1'b0;
        rd_to_wb            = '0;
        write_reg_to_wb     = 1'b0;
        read_mem_to_wb      = 1'b0;
        result_to_wb        = '0;
        data_from_mem_to_wb = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign_trap       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    dmem_req      = 1'b1;
                    dmem_we       = capture.write_mem;
                    dmem_addr     = {capture.addr[31:2], 2'b00};
                    dmem_be       = capture.be;
                    dmem_wdata    = capture.wdata;
                    stall_to_pipe = 1'b1;
                    state_nxt     = WAIT;
                end else begin
                    rd_to_wb        = rd_from_ex;
                    write_reg_to_wb = write_reg_from_ex & valid_from_ex & ~misalign;
                    read_mem_to_wb  = read_mem_from_ex;
                    result_to_wb    = result_from_ex;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    misalign_trap   = misalign;
`endif
                end
            end
            WAIT: begin
                dmem_req      = 1'b1;
                dmem_we       = hold.write_mem;
                dmem_addr     = {hold.addr[31:2], 2'b00};
                dmem_be       = hold.be;
                dmem_wdata    = hold.wdata;
                stall_to_pipe = 1'b1;
                if (dmem_ack) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    bus_err   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: begin
                rd_to_wb            = hold.rd;
                write_reg_to_wb     = hold.write_reg & ~err;
                read_mem_to_wb      = hold.read_mem & ~hold.write_mem;
                result_to_wb        = hold.addr;
                data_from_mem_to_wb = ld_data;
                state_nxt           = IDLE;
            end
        endcase

        if (rst) begin
            dmem_req            = 1'b0;
            dmem_we             = 1'b0;
            dmem_addr           = '0;
            dmem_be             = '0;
            dmem_wdata          = '0;
            stall_to_pipe       = 1'b0;
            bus_err             = 1'b0;
            rd_to_wb            = '0;
            write_reg_to_wb     = 1'b0;
            read_mem_to_wb      = 1'b0;
            result_to_wb        = '0;
            data_from_mem_to_wb = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_trap       = 1'b0;
`endif
        end
    end

endmodule
